// File: rtl/mcu_output_sequencer_if.sv
// rtl/mcu_output_sequencer_if.sv - frame input and SPI-side handshake bundle for the output sequencer
interface mcu_output_sequencer_if;
  logic        configured_in;
  logic        angles_valid_in;
  logic [15:0] roll_in;
  logic [15:0] pitch_in;
  logic [15:0] yaw_in;
  logic        done_in;
  logic        write_enable_out;
  logic [1:0]  output_select_out;
  logic [15:0] roll_out;
  logic [15:0] pitch_out;
  logic [15:0] yaw_out;
  logic        busy_out;
  logic        frame_done_out;
  logic        overrun_out;
  logic [7:0]  drop_count_out;
  logic        timeout_out;

  modport master (
    output configured_in, angles_valid_in, roll_in, pitch_in, yaw_in, done_in,
    input  write_enable_out, output_select_out, roll_out, pitch_out, yaw_out,
           busy_out, frame_done_out, overrun_out, drop_count_out, timeout_out
  );

  modport slave (
    input  configured_in, angles_valid_in, roll_in, pitch_in, yaw_in, done_in,
    output write_enable_out, output_select_out, roll_out, pitch_out, yaw_out,
           busy_out, frame_done_out, overrun_out, drop_count_out, timeout_out
  );
endinterface

// File: rtl/mcu_output_sequencer.sv
// rtl/mcu_output_sequencer.sv - feeds one latched roll/pitch/yaw frame to the SPI interface word by word
module mcu_output_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic                  clk,
  input logic                  n_rst,
  mcu_output_sequencer_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, WE_R, WAIT_R, WE_P, WAIT_P, WE_Y, WAIT_Y
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   roll_q, roll_d, pitch_q, pitch_d, yaw_q, yaw_d;
  logic [7:0]    drop_q, drop_d;
  logic          we_q, we_d, busy_q, busy_d;
  logic [1:0]    sel_q, sel_d;
  logic          fd_q, fd_d, ov_q, ov_d, to_q, to_d;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      roll_q  <= '0;
      pitch_q <= '0;
      yaw_q   <= '0;
      drop_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      sel_q   <= 2'b00;
      fd_q    <= 1'b0;
      ov_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      roll_q  <= roll_d;
      pitch_q <= pitch_d;
      yaw_q   <= yaw_d;
      drop_q  <= drop_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      sel_q   <= sel_d;
      fd_q    <= fd_d;
      ov_q    <= ov_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    roll_d  = roll_q;
    pitch_d = pitch_q;
    yaw_d   = yaw_q;
    drop_d  = drop_q;
    fd_d    = 1'b0;
    ov_d    = 1'b0;
    to_d    = 1'b0;

    if (state_q != IDLE && bus.angles_valid_in) begin
      ov_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (bus.angles_valid_in && bus.configured_in) begin
          roll_d  = bus.roll_in;
          pitch_d = bus.pitch_in;
          yaw_d   = bus.yaw_in;
          state_d = WE_R;
        end
      end
      WE_R: state_d = WAIT_R;
      WE_P: state_d = WAIT_P;
      WE_Y: state_d = WAIT_Y;
      WAIT_R, WAIT_P, WAIT_Y: begin
        // done on the last allowed wait cycle still wins over the timeout
        if (bus.done_in) begin
          if (state_q == WAIT_R)      state_d = WE_P;
          else if (state_q == WAIT_P) state_d = WE_Y;
          else begin
            state_d = IDLE;
            fd_d    = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // losing configuration abandons the frame silently
    if (state_q != IDLE && !bus.configured_in) begin
      state_d = IDLE;
      fd_d    = 1'b0;
      to_d    = 1'b0;
    end

    if (state_d != state_q) cnt_d = '0;

    we_d   = (state_d == WE_R) || (state_d == WE_P) || (state_d == WE_Y);
    busy_d = (state_d != IDLE);
    if (state_d == WE_P || state_d == WAIT_P)      sel_d = 2'b01;
    else if (state_d == WE_Y || state_d == WAIT_Y) sel_d = 2'b10;
    else                                           sel_d = 2'b00;
  end

  assign bus.write_enable_out  = we_q;
  assign bus.output_select_out = sel_q;
  assign bus.roll_out          = roll_q;
  assign bus.pitch_out         = pitch_q;
  assign bus.yaw_out           = yaw_q;
  assign bus.busy_out          = busy_q;
  assign bus.frame_done_out    = fd_q;
  assign bus.overrun_out       = ov_q;
  assign bus.drop_count_out    = drop_q;
  assign bus.timeout_out       = to_q;
endmodule
